corelet_ctrl: RTL and testbench

Sequencer that drives the corelet (L0, MAC array, OFIFO, SFU) for one convolution tile. It fetches weights and activations from activation SRAM into L0 and issues kernel-load and execute instructions. It then drains OFIFO partial sums into psum SRAM and replays them through the SFU for accumulation and ReLU. It sits between the top-level testbench/host and the corelet, owning every strobe the corelet consumes.

---
 rtl/corelet_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: one-tile sequencer for the corelet.
// It loads weights, then streams activations through L0 into the MAC array
// for each kernel position. OFIFO partial sums are drained into psum SRAM,
// then replayed through the SFU to accumulate and optionally ReLU each output.
// All outputs are registered. Reset is asynchronous and active-low.
module corelet_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int n_act  = 36,
  parameter int n_kij  = 9,
  parameter int addr_w = 11,
  parameter int w_base = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic              relu_en,
  input  logic              l0_full,
  input  logic              l0_ready,
  input  logic              ofifo_valid,
  input  logic              ofifo_full,
  output logic              busy,
  output logic              done,
  output logic              mode,
  output logic [1:0]        inst,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              ofifo_rd,
  output logic              acc,
  output logic              acc_init,
  output logic              relu,
  output logic              act_cen,
  output logic [addr_w-1:0] act_addr,
  output logic              psum_cen,
  output logic              psum_wen,
  output logic [addr_w-1:0] psum_addr,
  output logic              out_valid,
  output logic [addr_w-1:0] out_addr,
  output logic [3:0]        kij
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WSHIFT,
    S_XRUN,
    S_DRAIN,
    S_ACC,
    S_DONE
  } state_t;

  // Every phase counter shares one width; it is wide enough for any sane tile.
  localparam int cw = 16;
  localparam logic [cw-1:0] one_c    = cw'(1);
  localparam logic [cw-1:0] row_c    = cw'(row);
  localparam logic [cw-1:0] sh_end_c = cw'(row + col);
  localparam logic [cw-1:0] n_act_c  = cw'(n_act);
  localparam logic [cw-1:0] n_kij_c  = cw'(n_kij);
  localparam logic [3:0]    kij_last = 4'(n_kij - 1);

  state_t        state_reg;
  logic          relu_en_reg;
  logic [cw-1:0] rd_cnt_reg;   // SRAM reads issued in WLOAD / XRUN
  logic [cw-1:0] sh_cnt_reg;   // WSHIFT progress: kernel-load cycles, then propagation
  logic [cw-1:0] ex_cnt_reg;   // execute instructions issued in XRUN
  logic [cw-1:0] dr_cnt_reg;   // OFIFO pops in DRAIN
  logic [cw-1:0] out_cnt_reg;  // output index being accumulated in ACC
  logic [cw-1:0] step_reg;     // cycle within the current output in ACC
  logic [cw-1:0] acc_end;      // last step of one output (the out_valid step)
  logic          unused_ofifo_full;

  // One output takes n_kij reads, one trailing acc, an optional relu and out_valid.
  assign acc_end = relu_en_reg ? (n_kij_c + cw'(2)) : (n_kij_c + one_c);

  // Draining is paced purely by ofifo_valid, so the full flag carries no extra information.
  assign unused_ofifo_full = ofifo_full;

  // Tile sequencer: state, phase counters and every registered strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      relu_en_reg <= 1'b0;
      rd_cnt_reg  <= '0;
      sh_cnt_reg  <= '0;
      ex_cnt_reg  <= '0;
      dr_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      step_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mode        <= 1'b0;
      inst        <= 2'b00;
      l0_wr       <= 1'b0;
      l0_rd       <= 1'b0;
      ofifo_rd    <= 1'b0;
      acc         <= 1'b0;
      acc_init    <= 1'b0;
      relu        <= 1'b0;
      act_cen     <= 1'b1;
      act_addr    <= '0;
      psum_cen    <= 1'b1;
      psum_wen    <= 1'b1;
      psum_addr   <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      kij         <= '0;
    end else begin
      // Pulses and enables idle unless a state drives them this cycle.
      done      <= 1'b0;
      inst      <= 2'b00;
      l0_rd     <= 1'b0;
      ofifo_rd  <= 1'b0;
      acc       <= 1'b0;
      acc_init  <= 1'b0;
      relu      <= 1'b0;
      out_valid <= 1'b0;
      act_cen   <= 1'b1;
      psum_cen  <= 1'b1;
      psum_wen  <= 1'b1;
      // Activation SRAM has one cycle of read latency: write L0 the cycle after a read.
      l0_wr     <= ~act_cen;

      case (state_reg)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state_reg   <= S_WLOAD;
            busy        <= 1'b1;
            kij         <= '0;
            mode        <= mode_in;
            relu_en_reg <= relu_en;
            // Issue the first weight read on the accepting edge to save a cycle.
            if (!l0_full) begin
              act_cen    <= 1'b0;
              act_addr   <= addr_w'(w_base);
              rd_cnt_reg <= one_c;
            end else begin
              rd_cnt_reg <= '0;
            end
          end
        end

        S_WLOAD: begin
          if (rd_cnt_reg == row_c) begin
            // The last read's L0 write lands in the first WSHIFT cycle,
            // one cycle ahead of the first kernel-load read.
            state_reg  <= S_WSHIFT;
            sh_cnt_reg <= '0;
          end else if (!l0_full) begin
            act_cen    <= 1'b0;
            act_addr   <= addr_w'(w_base + int'(kij) * row + int'(rd_cnt_reg));
            rd_cnt_reg <= rd_cnt_reg + one_c;
          end
        end

        S_WSHIFT: begin
          if (sh_cnt_reg == sh_end_c) begin
            state_reg  <= S_XRUN;
            rd_cnt_reg <= '0;
            ex_cnt_reg <= '0;
          end else if (sh_cnt_reg < row_c) begin
            // Kernel-load reads only advance while L0 has a word ready.
            if (l0_ready) begin
              l0_rd      <= 1'b1;
              inst       <= 2'b01;
              sh_cnt_reg <= sh_cnt_reg + one_c;
            end
          end else begin
            // Idle cycles let the loaded weights settle across all columns.
            sh_cnt_reg <= sh_cnt_reg + one_c;
          end
        end

        S_XRUN: begin
          if (rd_cnt_reg == n_act_c && ex_cnt_reg == n_act_c) begin
            state_reg  <= S_DRAIN;
            dr_cnt_reg <= '0;
          end else begin
            // Fill and execute run independently so L0 can stream.
            if (rd_cnt_reg != n_act_c && !l0_full) begin
              act_cen    <= 1'b0;
              act_addr   <= addr_w'(rd_cnt_reg);
              rd_cnt_reg <= rd_cnt_reg + one_c;
            end
            if (ex_cnt_reg != n_act_c && l0_ready) begin
              l0_rd      <= 1'b1;
              inst       <= 2'b10;
              ex_cnt_reg <= ex_cnt_reg + one_c;
            end
          end
        end

        S_DRAIN: begin
          if (dr_cnt_reg == n_act_c) begin
            if (kij != kij_last) begin
              kij        <= kij + 4'd1;
              state_reg  <= S_WLOAD;
              rd_cnt_reg <= '0;
            end else begin
              state_reg   <= S_ACC;
              out_cnt_reg <= '0;
              step_reg    <= '0;
            end
          end else if (ofifo_valid) begin
            // Each pop goes straight into psum SRAM, laid out kij-major.
            ofifo_rd   <= 1'b1;
            psum_cen   <= 1'b0;
            psum_wen   <= 1'b0;
            psum_addr  <= addr_w'(int'(kij) * n_act + int'(dr_cnt_reg));
            dr_cnt_reg <= dr_cnt_reg + one_c;
          end
        end

        S_ACC: begin
          // Steps 0..n_kij-1 read one partial sum per kernel position.
          if (step_reg < n_kij_c) begin
            psum_cen  <= 1'b0;
            psum_addr <= addr_w'(int'(step_reg) * n_act + int'(out_cnt_reg));
          end
          // The SFU takes each word the cycle after its read; the first one seeds the sum.
          if (step_reg != '0 && step_reg <= n_kij_c) begin
            acc      <= 1'b1;
            acc_init <= (step_reg == one_c);
          end
          if (relu_en_reg && step_reg == n_kij_c + one_c) begin
            relu <= 1'b1;
          end
          if (step_reg == acc_end) begin
            out_valid <= 1'b1;
            out_addr  <= addr_w'(out_cnt_reg);
            step_reg  <= '0;
            if (out_cnt_reg == n_act_c - one_c) begin
              state_reg <= S_DONE;
            end else begin
              out_cnt_reg <= out_cnt_reg + one_c;
            end
          end else begin
            step_reg <= step_reg + one_c;
          end
        end

        S_DONE: begin
          // busy stays high through the done cycle and drops in IDLE.
          done      <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized scoreboard bench for corelet_ctrl.
// A tile-level reference model queues the expected SRAM traffic and outputs.
// A negedge monitor pops and compares them as the DUT presents them.
module tb_corelet_ctrl;

  localparam int ROW  = 4;
  localparam int COL  = 4;
  localparam int NACT = 4;
  localparam int NKIJ = 2;
  localparam int AW   = 11;
  localparam int WB   = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode_in = 1'b0;
  logic          relu_en = 1'b0;
  logic          l0_full = 1'b0;
  logic          l0_ready = 1'b1;
  logic          ofifo_valid = 1'b0;
  logic          ofifo_full = 1'b0;
  logic          busy, done, mode, l0_wr, l0_rd, ofifo_rd;
  logic          acc, acc_init, relu, act_cen, psum_cen, psum_wen, out_valid;
  logic [1:0]    inst;
  logic [AW-1:0] act_addr, psum_addr, out_addr;
  logic [3:0]    kij;

  corelet_ctrl #(
    .row(ROW), .col(COL), .n_act(NACT), .n_kij(NKIJ), .addr_w(AW), .w_base(WB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .relu_en(relu_en),
    .l0_full(l0_full), .l0_ready(l0_ready), .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
    .busy(busy), .done(done), .mode(mode), .inst(inst), .l0_wr(l0_wr), .l0_rd(l0_rd),
    .ofifo_rd(ofifo_rd), .acc(acc), .acc_init(acc_init), .relu(relu), .act_cen(act_cen),
    .act_addr(act_addr), .psum_cen(psum_cen), .psum_wen(psum_wen), .psum_addr(psum_addr),
    .out_valid(out_valid), .out_addr(out_addr), .kij(kij)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tile_no = 0;

  // Scoreboard queues filled by the model, drained by the monitor.
  int exp_act[$];
  int exp_pw[$];
  int exp_pr[$];
  int exp_out[$];

  int e;
  int last_ov = -1;
  int acc_n = 0, init_n = 0, relu_n = 0;
  int kload_n = 0, exec_n = 0, done_n = 0;
  bit prev_full = 0, prev_valid = 0, prev_ready = 0, prev_act_rd = 0;
  bit pw;
  bit xrun_seen = 0;
  bit relu_exp = 0, mode_exp = 0;
  bit stall_en = 0, toggle_en = 0;
  int full_hold = 0;

  task automatic chk(input bit ok, input string name, input int got, input int want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: the whole tile's expected traffic, straight from the dataflow rules.
  task automatic model_tile();
    for (int k = 0; k < NKIJ; k++) begin
      for (int i = 0; i < ROW; i++) exp_act.push_back(WB + k * ROW + i);
      for (int x = 0; x < NACT; x++) exp_act.push_back(x);
      for (int j = 0; j < NACT; j++) exp_pw.push_back(k * NACT + j);
    end
    for (int o = 0; o < NACT; o++) begin
      for (int c = 0; c < NKIJ; c++) exp_pr.push_back(c * NACT + o);
      exp_out.push_back(o);
    end
  endtask

  task automatic clear_sb();
    exp_act.delete();
    exp_pw.delete();
    exp_pr.delete();
    exp_out.delete();
  endtask

  // Status-input driver: quiet, random stalls, toggling OFIFO, or a forced full burst.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        l0_full     = ($urandom_range(0, 3) == 0);
        l0_ready    = ($urandom_range(0, 2) != 0);
        ofifo_valid = ($urandom_range(0, 1) == 1);
      end else begin
        l0_full     = 1'b0;
        l0_ready    = 1'b1;
        ofifo_valid = toggle_en ? ~ofifo_valid : 1'b1;
      end
      if (full_hold > 0) begin
        l0_full = 1'b1;
        full_hold--;
      end
      ofifo_full = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: compare every presented transaction against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      acc_n = 0; init_n = 0; relu_n = 0;
      prev_full = 0; prev_valid = 0; prev_ready = 0; prev_act_rd = 0;
    end else begin
      if (!act_cen) begin
        if (exp_act.size() == 0) chk(1'b0, "act_rd_unexpected", int'(act_addr), -1);
        else begin
          e = exp_act.pop_front();
          chk(int'(act_addr) == e, "act_addr", int'(act_addr), e);
        end
        chk(!prev_full, "act_rd_while_l0_full", int'(prev_full), 0);
        if (int'(act_addr) < WB) xrun_seen = 1;
      end
      if (l0_wr || prev_act_rd)
        chk(l0_wr == prev_act_rd, "l0_wr_after_read", int'(l0_wr), int'(prev_act_rd));
      if (l0_rd) begin
        chk(prev_ready, "l0_rd_without_ready", int'(prev_ready), 1);
        chk(inst != 2'b00, "l0_rd_inst", int'(inst), 1);
        if (inst == 2'b01) kload_n++;
        if (inst == 2'b10) exec_n++;
      end
      pw = !psum_cen && !psum_wen;
      if (ofifo_rd || pw) chk(ofifo_rd == pw, "pop_with_psum_wr", int'(ofifo_rd), int'(pw));
      if (ofifo_rd) chk(prev_valid, "pop_without_valid", int'(prev_valid), 1);
      if (pw) begin
        if (exp_pw.size() == 0) chk(1'b0, "psum_wr_unexpected", int'(psum_addr), -1);
        else begin
          e = exp_pw.pop_front();
          chk(int'(psum_addr) == e, "psum_wr_addr", int'(psum_addr), e);
          chk(int'(kij) == e / NACT, "kij_in_drain", int'(kij), e / NACT);
        end
      end
      if (!psum_cen && psum_wen) begin
        if (exp_pr.size() == 0) chk(1'b0, "psum_rd_unexpected", int'(psum_addr), -1);
        else begin
          e = exp_pr.pop_front();
          chk(int'(psum_addr) == e, "psum_rd_addr", int'(psum_addr), e);
        end
      end
      if (acc_init) chk(acc, "acc_init_without_acc", int'(acc), 1);
      acc_n  += int'(acc);
      init_n += int'(acc_init);
      relu_n += int'(relu);
      if (out_valid) begin
        if (exp_out.size() == 0) chk(1'b0, "out_unexpected", int'(out_addr), -1);
        else begin
          e = exp_out.pop_front();
          chk(int'(out_addr) == e, "out_addr", int'(out_addr), e);
        end
        chk(acc_n == NKIJ, "acc_per_output", acc_n, NKIJ);
        chk(init_n == 1, "acc_init_per_output", init_n, 1);
        chk(relu_n == int'(relu_exp), "relu_per_output", relu_n, int'(relu_exp));
        if (last_ov >= 0)
          chk(cyc - last_ov == NKIJ + 2 + int'(relu_exp), "out_valid_spacing",
              cyc - last_ov, NKIJ + 2 + int'(relu_exp));
        last_ov = cyc;
        acc_n = 0; init_n = 0; relu_n = 0;
      end
      if (done) done_n++;
      prev_full   = l0_full;
      prev_valid  = ofifo_valid;
      prev_ready  = l0_ready;
      prev_act_rd = !act_cen;
    end
  end

  task automatic pulse_start(input bit m, input bit r);
    @(posedge clk);
    #1;
    start = 1'b1; mode_in = m; relu_en = r;
    @(posedge clk);
    #1;
    // Flip the sampled inputs after acceptance; the latched copies must not follow.
    start = 1'b0; mode_in = ~m; relu_en = ~r;
  endtask

  task automatic run_tile(input bit m, input bit r, input bit timing_chk, input bit poke);
    int d0;
    int t0;
    model_tile();
    mode_exp = m; relu_exp = r; last_ov = -1;
    kload_n = 0; exec_n = 0; acc_n = 0; init_n = 0; relu_n = 0;
    d0 = done_n;
    t0 = cyc;
    pulse_start(m, r);
    if (timing_chk) begin
      @(negedge clk); #1;
      chk(busy == 1'b1, "busy_after_start", int'(busy), 1);
      chk(act_cen == 1'b0, "first_act_rd_t1", int'(act_cen), 0);
      @(negedge clk); #1;
      chk(l0_wr == 1'b1, "first_l0_wr_t2", int'(l0_wr), 1);
    end
    if (poke) begin
      repeat (20) @(posedge clk);
      #1; start = 1'b1;
      @(posedge clk);
      #1; start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_n == d0; i++) begin
      @(negedge clk); #1;
    end
    chk(done_n == d0 + 1, "done_pulse", done_n - d0, 1);
    chk(busy == 1'b1, "busy_during_done", int'(busy), 1);
    chk(exp_act.size() + exp_pw.size() + exp_pr.size() + exp_out.size() == 0, "sb_drained",
        exp_act.size() + exp_pw.size() + exp_pr.size() + exp_out.size(), 0);
    chk(kload_n == NKIJ * ROW, "kernel_load_count", kload_n, NKIJ * ROW);
    chk(exec_n == NKIJ * NACT, "execute_count", exec_n, NKIJ * NACT);
    chk(mode == mode_exp, "mode_latched", int'(mode), int'(mode_exp));
    chk(int'(kij) == NKIJ - 1, "kij_final", int'(kij), NKIJ - 1);
    @(negedge clk); #1;
    chk(busy == 1'b0, "busy_after_done", int'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
    chk(done_n == d0 + 1, "single_done", done_n - d0, 1);
    tile_no++;
    $display("tile %0d: mode=%0d relu=%0d stall=%0d toggle=%0d poke=%0d, %0d cycles",
             tile_no, m, r, stall_en, toggle_en, poke, cyc - t0);
    clear_sb();
  endtask

  task automatic reset_mid_xrun();
    model_tile();
    relu_exp = 0; last_ov = -1;
    xrun_seen = 0;
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < 2000 && !xrun_seen; i++) begin
      @(negedge clk); #1;
    end
    chk(xrun_seen, "reached_xrun", int'(xrun_seen), 1);
    @(negedge clk); #1;
    chk(l0_wr == 1'b1, "l0_wr_before_reset", int'(l0_wr), 1);
    reset = 1'b0;
    #1;
    chk(busy == 1'b0, "busy_in_reset", int'(busy), 0);
    chk(l0_wr == 1'b0, "l0_wr_in_reset", int'(l0_wr), 0);
    chk(act_cen == 1'b1, "act_cen_in_reset", int'(act_cen), 1);
    chk(int'(kij) == 0 && mode == 1'b0, "kij_mode_in_reset", int'(kij) * 2 + int'(mode), 0);
    clear_sb();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    $display("reset asserted mid-XRUN at cycle %0d", cyc);
  endtask

  logic [14:0] strobes;

  initial begin
    // Reset held, then released with no start.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk(busy == 1'b0 && act_cen == 1'b1 && psum_cen == 1'b1, "outputs_while_in_reset",
        int'({busy, act_cen, psum_cen}), 3);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      strobes = {busy, done, inst, l0_wr, l0_rd, ofifo_rd, acc, acc_init, relu,
                 act_cen, psum_cen, psum_wen, out_valid, mode};
      chk(strobes == 15'b000000000011100, "idle_strobes", int'(strobes), 28);
      chk(act_addr == '0 && psum_addr == '0 && out_addr == '0 && kij == 4'd0, "idle_addrs",
          int'(act_addr) + int'(psum_addr) + int'(out_addr) + int'(kij), 0);
    end

    // Stall-free tiles, with and without ReLU; a stray start mid-tile is ignored.
    run_tile(1'b0, 1'b0, 1'b1, 1'b0);
    run_tile(1'b1, 1'b1, 1'b1, 1'b1);

    // OFIFO valid alternating every cycle while draining.
    toggle_en = 1;
    run_tile(1'b0, 1'b1, 1'b0, 1'b0);
    toggle_en = 0;

    // L0 full for five cycles once activation streaming has begun.
    xrun_seen = 0;
    fork
      run_tile(1'b1, 1'b0, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 3000 && !xrun_seen; i++) @(negedge clk);
        full_hold = 5;
      end
    join

    // Reset mid-XRUN, then a complete tile starting again from kij 0.
    reset_mid_xrun();
    run_tile(1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized L0 / OFIFO stalls.
    stall_en = 1;
    for (int t = 0; t < 5; t++) begin
      run_tile(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
               1'($urandom_range(0, 1)));
    end
    stall_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
